// File: rtl/iq_mix_accum_pkg.sv
// Shared definitions for the IQ mixer/accumulator: FSM state encoding, default widths, result width helper.
// The optional windowed-mean output is selected by the IQ_MIX_AVG_EN macro in the top.
package iq_mix_accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DEF_N        = 14;
    localparam int DEF_REF_W    = 12;
    localparam int DEF_LOG2_LEN = 10;

    // Product width plus one bit per doubling of the window keeps the full-window sum exact.
    function automatic int out_width(input int n, input int ref_w, input int log2_len);
        return n + ref_w + log2_len;
    endfunction

endpackage

// File: rtl/iq_mac_lane.sv
// One multiply-accumulate lane: registered full-precision product, then a load/accumulate adder.
// Window framing (first/last tags, flushing) is owned by the parent.
module iq_mac_lane
    import iq_mix_accum_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int REF_W    = DEF_REF_W,
    parameter int LOG2_LEN = DEF_LOG2_LEN,
    parameter int OUT_W    = out_width(DEF_N, DEF_REF_W, DEF_LOG2_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mul_en_i,
    input  logic signed [N-1:0]     sample_i,
    input  logic signed [REF_W-1:0] ref_i,
    input  logic                    acc_en_i,
    input  logic                    acc_load_i,
    output logic signed [OUT_W-1:0] sum_o
);

    localparam int PW = N + REF_W;

    logic signed [PW-1:0]    sample_ext;
    logic signed [PW-1:0]    ref_ext;
    logic signed [PW-1:0]    prod_d;
    logic signed [PW-1:0]    prod_q;
    logic signed [OUT_W-1:0] prod_ext;
    logic signed [OUT_W-1:0] acc_d;
    logic signed [OUT_W-1:0] acc_q;

    // Operands widened to the product width so the multiply is exact.
    assign sample_ext = {{REF_W{sample_i[N-1]}}, sample_i};
    assign ref_ext    = {{N{ref_i[REF_W-1]}}, ref_i};
    assign prod_d     = sample_ext * ref_ext;

    assign prod_ext = {{(OUT_W - PW){prod_q[PW-1]}}, prod_q};
    assign acc_d    = acc_load_i ? prod_ext : (acc_q + prod_ext);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (mul_en_i) begin
                prod_q <= prod_d;
            end
            if (acc_en_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign sum_o = acc_q;

endmodule

// File: rtl/iq_mix_accum.sv
// IQ mixer: multiplies samples by NCO references and sums both products over 2^LOG2_LEN-sample windows.
// Define IQ_MIX_AVG_EN to output the rounded window mean instead of the raw sum (one extra cycle).
module iq_mix_accum
    import iq_mix_accum_pkg::*;
#(
    parameter int  N        = DEF_N,
    parameter int  REF_W    = DEF_REF_W,
    parameter int  LOG2_LEN = DEF_LOG2_LEN,
    localparam int OUT_W    = out_width(N, REF_W, LOG2_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic signed [N-1:0]     sample_in,
    input  logic                    sample_valid,
    input  logic signed [REF_W-1:0] ref_i,
    input  logic signed [REF_W-1:0] ref_q,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;

    state_t              state_q;
    logic [LOG2_LEN-1:0] cnt_q;
    logic                accept;

    logic s1_valid_q;
    logic s1_first_q;
    logic s1_last_q;
    logic s2_last_q;

    logic signed [REF_W-1:0] lane_ref [2];
    logic signed [OUT_W-1:0] lane_sum [2];

    logic                    res_valid;
    logic signed [OUT_W-1:0] res_i;
    logic signed [OUT_W-1:0] res_q;

    logic                    out_valid_d, out_valid_q;
    logic                    overrun_d, overrun_q;
    logic signed [OUT_W-1:0] i_out_d, i_out_q;
    logic signed [OUT_W-1:0] q_out_d, q_out_q;

    // Dropping run also blocks new samples, so the partial window never reaches the pipeline.
    assign accept = sample_valid && run && (state_q == ACCUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= ACCUM;
                        cnt_q   <= '0;
                    end
                end
                ACCUM: begin
                    if (!run) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        cnt_q <= cnt_q + LOG2_LEN'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Window tags ride alongside each product; a low run kills any close tag still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_first_q <= (cnt_q == '0);
            s1_last_q  <= (cnt_q == CNT_LAST);
            s2_last_q  <= run && s1_valid_q && s1_last_q;
        end
    end

    assign lane_ref[0] = ref_i;
    assign lane_ref[1] = ref_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            iq_mac_lane #(
                .N        (N),
                .REF_W    (REF_W),
                .LOG2_LEN (LOG2_LEN),
                .OUT_W    (OUT_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .mul_en_i   (accept),
                .sample_i   (sample_in),
                .ref_i      (lane_ref[gi]),
                .acc_en_i   (s1_valid_q),
                .acc_load_i (s1_first_q),
                .sum_o      (lane_sum[gi])
            );
        end
    endgenerate

`ifdef IQ_MIX_AVG_EN
    localparam logic signed [OUT_W-1:0] ROUND = {{(OUT_W-1){1'b0}}, 1'b1} << (LOG2_LEN - 1);

    logic                    s3_last_q;
    logic signed [OUT_W-1:0] avg_i_q;
    logic signed [OUT_W-1:0] avg_q_q;

    // Round half up, then arithmetic shift keeps the sign across the full output width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_last_q <= 1'b0;
            avg_i_q   <= '0;
            avg_q_q   <= '0;
        end else begin
            s3_last_q <= run && s2_last_q;
            if (s2_last_q) begin
                avg_i_q <= (lane_sum[0] + ROUND) >>> LOG2_LEN;
                avg_q_q <= (lane_sum[1] + ROUND) >>> LOG2_LEN;
            end
        end
    end

    assign res_valid = s3_last_q;
    assign res_i     = avg_i_q;
    assign res_q     = avg_q_q;
`else
    assign res_valid = s2_last_q;
    assign res_i     = lane_sum[0];
    assign res_q     = lane_sum[1];
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        // A finished window lands only if the holding register is empty or being read this cycle.
        if (res_valid) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                i_out_d     = res_i;
                q_out_d     = res_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;

endmodule
